// File: rtl/control_multiciclo_pkg.sv
// Shared definitions for the multicycle MIPS control path.
// The state codes, opcode constants and AluOP codes live here so that the
// ALU control decoder can import the same values as control_multiciclo.
// The package has no ports. It provides:
//   state_e       - FSM state codes 0..11 (codes 12..15 are unused)
//   OP_*          - primary opcode values (instruction bits [31:26])
//   ALUOP_*       - AluOP codes sent to the ALU control decoder
//   SRCB_*/PCSRC_* - datapath mux select codes
//   ctrl_t        - bundle of every control output
//   op_supported  - returns 1 for opcodes the FSM knows how to execute
package control_multiciclo_pkg;

    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_MEMADR = 4'd2,
        S_MEMRD  = 4'd3,
        S_MEMWB  = 4'd4,
        S_MEMWR  = 4'd5,
        S_EXEC   = 4'd6,
        S_RCOMP  = 4'd7,
        S_BRANCH = 4'd8,
        S_JUMP   = 4'd9,
        S_ADDIEX = 4'd10,
        S_ADDIWB = 4'd11
    } state_e;

    localparam logic [5:0] OP_R    = 6'b000000;
    localparam logic [5:0] OP_LW   = 6'b100011;
    localparam logic [5:0] OP_SW   = 6'b101011;
    localparam logic [5:0] OP_BEQ  = 6'b000100;
    localparam logic [5:0] OP_J    = 6'b000010;
    localparam logic [5:0] OP_ADDI = 6'b001000;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    localparam logic [1:0] SRCB_REGB  = 2'b00;
    localparam logic [1:0] SRCB_FOUR  = 2'b01;
    localparam logic [1:0] SRCB_IMM   = 2'b10;
    localparam logic [1:0] SRCB_IMMSH = 2'b11;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    typedef struct packed {
        logic       pc_write;
        logic       pc_write_cond;
        logic       iord;
        logic       mem_read;
        logic       mem_write;
        logic       mem_to_reg;
        logic       ir_write;
        logic       alu_src_a;
        logic       reg_write;
        logic       reg_dst;
        logic [1:0] alu_src_b;
        logic [1:0] pc_source;
        logic [1:0] alu_op;
        logic       ilegal;
        logic [3:0] estado;
    } ctrl_t;

    function automatic logic op_supported(input logic [5:0] op);
        return (op == OP_R) || (op == OP_LW) || (op == OP_SW) ||
               (op == OP_BEQ) || (op == OP_J) || (op == OP_ADDI);
    endfunction

endpackage

// File: rtl/control_multiciclo.sv
// Moore control FSM for a multicycle MIPS datapath (R-type, lw, sw, beq,
// j, addi). Every output decodes from the registered state, except ilegal,
// which also looks at the opcode while in DECODE.
// Ports:
//   clk, rst          - rising-edge clock, synchronous active-high reset
//   opcode            - instruction bits [31:26]; sampled only in DECODE/MEMADR
//   AluOP             - 00 add, 01 subtract, 10 decode funct
//   PCWrite .. RegDst - single-bit datapath enables/selects
//   ALUSrcB, PCSource - 2-bit datapath mux selects
//   ilegal            - one-cycle flag for an unsupported opcode in DECODE
//   estado            - current state code (debug)
// While rst is high every output, estado included, is held at 0.
module control_multiciclo
    import control_multiciclo_pkg::*;
#(
    parameter int SIZEOP      = 6,
    parameter int SIZE_ALU_OP = 2
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [SIZEOP-1:0]      opcode,
    output logic [SIZE_ALU_OP-1:0] AluOP,
    output logic                   PCWrite,
    output logic                   PCWriteCond,
    output logic                   IorD,
    output logic                   MemRead,
    output logic                   MemWrite,
    output logic                   MemtoReg,
    output logic                   IRWrite,
    output logic                   ALUSrcA,
    output logic                   RegWrite,
    output logic                   RegDst,
    output logic [1:0]             ALUSrcB,
    output logic [1:0]             PCSource,
    output logic                   ilegal,
    output logic [3:0]             estado
);

    state_e     state_q, state_d;
    logic [5:0] op6;
    ctrl_t      ctrl;

    // Opcode constants are 6 bits wide; adapt a non-default SIZEOP once here.
    always_comb op6 = 6'(opcode);

    always_ff @(posedge clk) begin
        if (rst) state_q <= S_FETCH;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = S_FETCH;
        case (state_q)
            S_FETCH:  state_d = S_DECODE;
            S_DECODE: begin
                case (op6)
                    OP_R:         state_d = S_EXEC;
                    OP_LW, OP_SW: state_d = S_MEMADR;
                    OP_BEQ:       state_d = S_BRANCH;
                    OP_J:         state_d = S_JUMP;
                    OP_ADDI:      state_d = S_ADDIEX;
                    default:      state_d = S_FETCH;
                endcase
            end
            // The opcode is looked at again to pick load vs store; anything
            // else here means the instruction register changed under us, so
            // the instruction is abandoned.
            S_MEMADR: begin
                if (op6 == OP_LW)      state_d = S_MEMRD;
                else if (op6 == OP_SW) state_d = S_MEMWR;
                else                   state_d = S_FETCH;
            end
            S_MEMRD:  state_d = S_MEMWB;
            S_EXEC:   state_d = S_RCOMP;
            S_ADDIEX: state_d = S_ADDIWB;
            // MEMWB, MEMWR, RCOMP, BRANCH, JUMP, ADDIWB and the unused
            // codes 12..15 all return to FETCH.
            default:  state_d = S_FETCH;
        endcase
    end

    always_comb begin
        ctrl = '0;
        if (!rst) begin
            ctrl.estado = state_q;
            case (state_q)
                S_FETCH: begin
                    ctrl.mem_read  = 1'b1;
                    ctrl.ir_write  = 1'b1;
                    ctrl.alu_src_b = SRCB_FOUR;
                    ctrl.alu_op    = ALUOP_ADD;
                    ctrl.pc_source = PCSRC_ALU;
                    ctrl.pc_write  = 1'b1;
                end
                S_DECODE: begin
                    ctrl.alu_src_b = SRCB_IMMSH;
                    ctrl.alu_op    = ALUOP_ADD;
                    ctrl.ilegal    = !op_supported(op6);
                end
                S_MEMADR, S_ADDIEX: begin
                    ctrl.alu_src_a = 1'b1;
                    ctrl.alu_src_b = SRCB_IMM;
                    ctrl.alu_op    = ALUOP_ADD;
                end
                S_MEMRD: begin
                    ctrl.mem_read = 1'b1;
                    ctrl.iord     = 1'b1;
                end
                S_MEMWB: begin
                    ctrl.reg_write  = 1'b1;
                    ctrl.mem_to_reg = 1'b1;
                end
                S_MEMWR: begin
                    ctrl.mem_write = 1'b1;
                    ctrl.iord      = 1'b1;
                end
                S_EXEC: begin
                    ctrl.alu_src_a = 1'b1;
                    ctrl.alu_src_b = SRCB_REGB;
                    ctrl.alu_op    = ALUOP_FUNCT;
                end
                S_RCOMP: begin
                    ctrl.reg_write = 1'b1;
                    ctrl.reg_dst   = 1'b1;
                end
                S_BRANCH: begin
                    ctrl.alu_src_a     = 1'b1;
                    ctrl.alu_src_b     = SRCB_REGB;
                    ctrl.alu_op        = ALUOP_SUB;
                    ctrl.pc_write_cond = 1'b1;
                    ctrl.pc_source     = PCSRC_ALUOUT;
                end
                S_JUMP: begin
                    ctrl.pc_write  = 1'b1;
                    ctrl.pc_source = PCSRC_JUMP;
                end
                S_ADDIWB: begin
                    ctrl.reg_write = 1'b1;
                end
                default: ctrl = '0;
            endcase
        end
    end

    assign AluOP       = SIZE_ALU_OP'(ctrl.alu_op);
    assign PCWrite     = ctrl.pc_write;
    assign PCWriteCond = ctrl.pc_write_cond;
    assign IorD        = ctrl.iord;
    assign MemRead     = ctrl.mem_read;
    assign MemWrite    = ctrl.mem_write;
    assign MemtoReg    = ctrl.mem_to_reg;
    assign IRWrite     = ctrl.ir_write;
    assign ALUSrcA     = ctrl.alu_src_a;
    assign RegWrite    = ctrl.reg_write;
    assign RegDst      = ctrl.reg_dst;
    assign ALUSrcB     = ctrl.alu_src_b;
    assign PCSource    = ctrl.pc_source;
    assign ilegal      = ctrl.ilegal;
    assign estado      = ctrl.estado;

endmodule

// File: tb/tb_control_multiciclo.sv
module tb_control_multiciclo;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [5:0] opcode = 6'd0;
    logic [1:0] AluOP, ALUSrcB, PCSource;
    logic       PCWrite, PCWriteCond, IorD, MemRead, MemWrite, MemtoReg;
    logic       IRWrite, ALUSrcA, RegWrite, RegDst, ilegal;
    logic [3:0] estado;

    control_multiciclo #(.SIZEOP(6), .SIZE_ALU_OP(2)) dut (
        .clk(clk), .rst(rst), .opcode(opcode), .AluOP(AluOP),
        .PCWrite(PCWrite), .PCWriteCond(PCWriteCond), .IorD(IorD),
        .MemRead(MemRead), .MemWrite(MemWrite), .MemtoReg(MemtoReg),
        .IRWrite(IRWrite), .ALUSrcA(ALUSrcA), .RegWrite(RegWrite),
        .RegDst(RegDst), .ALUSrcB(ALUSrcB), .PCSource(PCSource),
        .ilegal(ilegal), .estado(estado)
    );

    always #5 clk = ~clk;

    localparam logic [5:0] R = 6'b000000, LW = 6'b100011, SW = 6'b101011;
    localparam logic [5:0] BEQ = 6'b000100, J = 6'b000010, ADDI = 6'b001000;

    typedef logic [20:0] vec_t;
    vec_t exp_q[$];
    int   n_chk = 0;
    int   n_pass = 0;

    function automatic logic known(input logic [5:0] op);
        return op inside {R, LW, SW, BEQ, J, ADDI};
    endfunction

    // State walked by an instruction at cycle idx (FETCH = idx 0); -1 when done.
    function automatic int path(input logic [5:0] op, input int idx);
        int p[5];
        int n;
        p = '{0, 1, 0, 0, 0};
        n = 2;
        case (op)
            R:    begin p = '{0, 1, 6, 7, 0};  n = 4; end
            LW:   begin p = '{0, 1, 2, 3, 4};  n = 5; end
            SW:   begin p = '{0, 1, 2, 5, 0};  n = 4; end
            BEQ:  begin p = '{0, 1, 8, 0, 0};  n = 3; end
            J:    begin p = '{0, 1, 9, 0, 0};  n = 3; end
            ADDI: begin p = '{0, 1, 10, 11, 0}; n = 4; end
            default: ;
        endcase
        return (idx < n) ? p[idx] : -1;
    endfunction

    // Expected outputs for a state, straight from the per-state control table.
    function automatic vec_t model_out(input int st, input logic [5:0] op);
        logic pcw, pcwc, iord, mr, mw, m2r, irw, srca, rw, rd, il;
        logic [1:0] srcb, pcs, aop;
        logic [3:0] code;
        {pcw, pcwc, iord, mr, mw, m2r, irw, srca, rw, rd, il} = '0;
        srcb = 2'b00; pcs = 2'b00; aop = 2'b00;
        code = 4'(st);
        case (st)
            0:  begin mr = 1; irw = 1; srcb = 2'b01; pcw = 1; end
            1:  begin srcb = 2'b11; il = !known(op); end
            2, 10: begin srca = 1; srcb = 2'b10; end
            3:  begin mr = 1; iord = 1; end
            4:  begin rw = 1; m2r = 1; end
            5:  begin mw = 1; iord = 1; end
            6:  begin srca = 1; aop = 2'b10; end
            7:  begin rw = 1; rd = 1; end
            8:  begin srca = 1; aop = 2'b01; pcwc = 1; pcs = 2'b01; end
            9:  begin pcw = 1; pcs = 2'b10; end
            11: begin rw = 1; end
            default: ;
        endcase
        return {pcw, pcwc, iord, mr, mw, m2r, irw, srca, rw, rd,
                srcb, pcs, aop, il, code};
    endfunction

    task automatic drive(input logic r, input logic [5:0] op, input vec_t e);
        @(posedge clk);
        #1;
        rst = r;
        opcode = op;
        exp_q.push_back(e);
    endtask

    // Runs one instruction; if rst_at >= 0, reset is held for rst_len cycles
    // starting at that cycle of the instruction, abandoning it.
    task automatic run_instr(input logic [5:0] op, input int rst_at, input int rst_len);
        int st;
        logic [5:0] d;
        for (int idx = 0; path(op, idx) >= 0; idx++) begin
            if (idx == rst_at) begin
                for (int k = 0; k < rst_len; k++) drive(1'b1, 6'($urandom), '0);
                return;
            end
            st = path(op, idx);
            // Opcode only matters in DECODE and MEMADR; scramble it elsewhere.
            d = (st == 1 || st == 2) ? op : 6'($urandom);
            drive(1'b0, d, model_out(st, op));
        end
    endtask

    vec_t mon_e, mon_got;
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            mon_e = exp_q.pop_front();
            mon_got = {PCWrite, PCWriteCond, IorD, MemRead, MemWrite, MemtoReg,
                       IRWrite, ALUSrcA, RegWrite, RegDst, ALUSrcB, PCSource,
                       AluOP, ilegal, estado};
            n_chk++;
            if (mon_got === mon_e) n_pass++;
            else $display("FAIL ctrl_outputs check %0d at %0t: got %h expected %h (estado got %0d expected %0d)",
                          n_chk, $time, mon_got, mon_e, mon_got[3:0], mon_e[3:0]);
        end
    end

    logic [5:0] pool[9];
    logic [5:0] op_r;

    initial begin
        pool = '{R, LW, SW, BEQ, J, ADDI, 6'b111111, 6'b000001, 6'b110000};
        for (int k = 0; k < 3; k++) drive(1'b1, 6'($urandom), '0);
        run_instr(R, -1, 0);
        run_instr(LW, -1, 0);
        run_instr(SW, -1, 0);
        run_instr(BEQ, -1, 0);
        run_instr(J, -1, 0);
        run_instr(ADDI, -1, 0);
        run_instr(6'b111111, -1, 0);
        run_instr(LW, 3, 2);        // reset during MEMRD
        run_instr(R, -1, 0);
        for (int n = 0; n < 250; n++) begin
            if ($urandom_range(0, 3) == 0) op_r = 6'($urandom);
            else op_r = pool[$urandom_range(0, 8)];
            if ($urandom_range(0, 14) == 0)
                run_instr(op_r, $urandom_range(0, 4), $urandom_range(1, 2));
            else
                run_instr(op_r, -1, 0);
        end
        drive(1'b0, 6'd0, model_out(0, 6'd0));
        repeat (3) @(negedge clk);
        n_chk++;
        if (exp_q.size() == 0) n_pass++;
        else $display("FAIL scoreboard_drain: got %0d entries left, expected 0", exp_q.size());
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/control_multiciclo.md
CONTROL_MULTICICLO -- requirements
Module: control_multiciclo

Interface
REQ-001 SHALL have parameter SIZEOP, default 6, meaning opcode field width.
REQ-002 SHALL have parameter SIZE_ALU_OP, default 2, meaning AluOP width driven to the ALU control decoder.
REQ-003 SHALL use one clock and a synchronous, active-high reset: clk  input  1  rising-edge clock.
REQ-004 rst  input  1  synchronous active-high reset.
REQ-005 opcode  input  SIZEOP  instruction bits [31:26] from the instruction register.
REQ-006 AluOP  output  SIZE_ALU_OP  00 add, 01 subtract, 10 decode funct.
REQ-007 PCWrite, PCWriteCond, IorD, MemRead, MemWrite, MemtoReg, IRWrite, ALUSrcA, RegWrite, RegDst  output  1 each  multicycle datapath controls.
REQ-008 ALUSrcB  output  2  00 regB, 01 constant 4, 10 sign-extended immediate, 11 immediate shifted left 2.
REQ-009 PCSource  output  2  00 ALU result, 01 ALUOut, 10 jump target.
REQ-010 ilegal  output  1  unsupported opcode flag.
REQ-011 estado  output  4  current state code, for debug.

Function
REQ-012 SHALL be a Moore FSM; all outputs SHALL decode from the registered state only, except ilegal.
REQ-013 States and codes: FETCH 0, DECODE 1, MEMADR 2, MEMRD 3, MEMWB 4, MEMWR 5, EXEC 6, RCOMP 7, BRANCH 8, JUMP 9, ADDIEX 10, ADDIWB 11; codes 12-15 SHALL go to FETCH on the next edge.
REQ-014 FETCH: MemRead=1, IRWrite=1, IorD=0, ALUSrcA=0, ALUSrcB=01, AluOP=00, PCSource=00, PCWrite=1; next DECODE.
REQ-015 DECODE: ALUSrcA=0, ALUSrcB=11, AluOP=00; next by opcode: 000000->EXEC, 100011 or 101011->MEMADR, 000100->BRANCH, 000010->JUMP, 001000->ADDIEX, other->FETCH.
REQ-016 ilegal SHALL be 1 only in DECODE with an unsupported opcode, for exactly one cycle.
REQ-017 MEMADR and ADDIEX: ALUSrcA=1, ALUSrcB=10, AluOP=00; MEMADR next MEMRD for 100011, MEMWR for 101011; ADDIEX next ADDIWB.
REQ-018 MEMRD: MemRead=1, IorD=1; next MEMWB. MEMWB: RegWrite=1, MemtoReg=1, RegDst=0; next FETCH.
REQ-019 MEMWR: MemWrite=1, IorD=1; next FETCH.
REQ-020 EXEC: ALUSrcA=1, ALUSrcB=00, AluOP=10; next RCOMP. RCOMP: RegWrite=1, RegDst=1, MemtoReg=0; next FETCH.
REQ-021 BRANCH: ALUSrcA=1, ALUSrcB=00, AluOP=01, PCWriteCond=1, PCSource=01; next FETCH.
REQ-022 JUMP: PCWrite=1, PCSource=10; next FETCH. ADDIWB: RegWrite=1, RegDst=0, MemtoReg=0; next FETCH.
REQ-023 Every output not listed for a state SHALL be 0 in that state.
REQ-024 Cycles per instruction, FETCH included: R-type 4, lw 5, sw 4, beq 3, j 3, addi 4, illegal 2.
REQ-025 The opcode SHALL be sampled only in DECODE and MEMADR; opcode changes in any other state SHALL have no effect.

Reset
REQ-026 rst=1 at a clock edge SHALL set state to FETCH, whatever the current state, including mid-instruction.
REQ-027 While rst=1, all outputs SHALL be 0, including ilegal and estado; the first FETCH outputs SHALL appear in the first cycle after rst falls.

Structure
REQ-028 State codes, opcode constants (R, LW, SW, BEQ, J, ADDI) and AluOP codes SHALL live in a shared package reused by the ALU control decoder.
REQ-029 SHALL be one module, with next-state logic and output decode as separate combinational processes; no sub-module.

Verification
REQ-030 Release rst, opcode=000000 -> estado 0,1,6,7,0; AluOP=10 in state 6; RegWrite=1 and RegDst=1 in state 7 only.
REQ-031 opcode=100011 -> estado 0,1,2,3,4,0; MemRead=1 in states 0 and 3; MemtoReg=1 and RegWrite=1 in state 4.
REQ-032 opcode=101011, then opcode=000100 -> estado 0,1,2,5,0 with MemWrite=1 only in state 5; then estado 0,1,8,0 with AluOP=01 and PCWriteCond=1 in state 8.
REQ-033 opcode=000010, then opcode=001000 -> JUMP: PCSource=10, PCWrite=1; ADDI: 0,1,10,11,0 with ALUSrcB=10 in state 10.
REQ-034 opcode=111111 -> ilegal=1 for one cycle in state 1, then state 0; opcode toggled during state 7 -> no path change.
REQ-035 Assert rst during MEMRD -> all outputs 0 while rst is high; estado=0 with FETCH outputs on the first cycle after release.
